// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock ratio meter: FSM encoding and parameter defaults.
package clk_meas_pkg;

    localparam int          DEF_CNT_W   = 32;
    localparam logic [31:0] DEF_TIMEOUT = 32'd1000000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } meas_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Brings a possibly asynchronous input into the clk_in domain and produces
// single-cycle rise/fall pulses from the synchronized level.
module sync_edge_det (
    input  logic clk_in,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic s1_reg;
    logic s2_reg;
    logic s3_reg;

    // Two synchronizer stages followed by a history stage for edge detection
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= sig_in;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign rise = s2_reg & ~s3_reg;
    assign fall = ~s2_reg & s3_reg;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a slow clock in clk_in cycles, flags a
// stable ratio (locked) and a stalled input (timeout).
module clk_ratio_meter
    import clk_meas_pkg::*;
#(
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(DEF_TIMEOUT)
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    // Counter ceiling; reaching it while measuring means the input stalled
    localparam logic [CNT_W-1:0] CNT_MAX = TIMEOUT - 1'b1;

    logic             rise;
    logic             fall;
    meas_state_t      state_reg;
    meas_state_t      state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hi_cap_reg;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] high_reg;
    logic             meas_valid_reg;
    logic             locked_reg;
    logic             timeout_reg;
    // Set while the first measurement of a MEASURE run is still pending;
    // that measurement has no valid predecessor to lock against.
    logic             first_reg;
    logic             do_meas;
    logic             do_tmo;
    logic             do_arm;

    sync_edge_det u_sync (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .sig_in  (sig_in),
        .rise    (rise),
        .fall    (fall)
    );

    assign cnt_inc = cnt_reg + 1'b1;

    // Next-state logic; a rise takes priority over a simultaneous timeout
    always_comb begin
        state_next = state_reg;
        do_meas    = 1'b0;
        do_tmo     = 1'b0;
        do_arm     = 1'b0;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: state_next = WAIT_RISE;
                WAIT_RISE: begin
                    if (rise) begin
                        state_next = MEASURE;
                        do_arm     = 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        do_meas = 1'b1;
                    end else if (cnt_reg == CNT_MAX) begin
                        do_tmo     = 1'b1;
                        state_next = WAIT_RISE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Cycle counter: restarts on each rise, saturates instead of wrapping
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n)                      cnt_reg <= '0;
        else if (!en || state_reg == IDLE) cnt_reg <= '0;
        else if (rise)                     cnt_reg <= '0;
        else if (cnt_reg != CNT_MAX)       cnt_reg <= cnt_inc;
    end

    // High-phase length captured at the falling edge
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n)  hi_cap_reg <= '0;
        else if (fall) hi_cap_reg <= cnt_inc;
    end

    // Measurement outputs, lock compare against previous result, stall flag
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            period_reg     <= '0;
            high_reg       <= '0;
            meas_valid_reg <= 1'b0;
            locked_reg     <= 1'b0;
            timeout_reg    <= 1'b0;
            first_reg      <= 1'b1;
        end else begin
            meas_valid_reg <= do_meas;
            if (do_arm) first_reg <= 1'b1;
            if (!en) begin
                locked_reg  <= 1'b0;
                timeout_reg <= 1'b0;
            end else if (do_meas) begin
                period_reg  <= cnt_inc;
                high_reg    <= hi_cap_reg;
                timeout_reg <= 1'b0;
                locked_reg  <= !first_reg && (cnt_inc == period_reg) && (hi_cap_reg == high_reg);
                first_reg   <= 1'b0;
            end else if (do_tmo) begin
                timeout_reg <= 1'b1;
                locked_reg  <= 1'b0;
            end
        end
    end

    assign period     = period_reg;
    assign high_time  = high_reg;
    assign meas_valid = meas_valid_reg;
    assign locked     = locked_reg;
    assign timeout    = timeout_reg;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Self-checking bench for clk_ratio_meter. sig_in is driven from a divider
// pattern; the reference model derives expected results from the time stamps
// of the driven edges (shifted by the 3-cycle input latency).
module tb_clk_ratio_meter;

    localparam int CNT_W = 32;
    localparam int TMO   = 100;
    localparam int MAXC  = 4096;

    logic             clk_in  = 1'b0;
    logic             reset_n = 1'b0;
    logic             en      = 1'b0;
    logic             sig_in  = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    clk_ratio_meter #(.CNT_W(CNT_W), .TIMEOUT(32'd100)) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .en         (en),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 clk_in = ~clk_in;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 4;
    logic drv_sig [MAXC];
    logic drv_en  [MAXC];
    int   div_pos = 0;

    // reference model state
    bit m_active, m_measuring, m_have_prev;
    int m_last_rise, m_last_fall;
    int exp_period, exp_high;
    bit exp_mv, exp_locked, exp_timeout;

    task automatic model_reset();
        m_active = 0; m_measuring = 0; m_have_prev = 0;
        exp_period = 0; exp_high = 0;
        exp_mv = 0; exp_locked = 0; exp_timeout = 0;
    endtask

    // Expected outputs after edge cyc: an input edge driven after edge k acts at edge k+3.
    task automatic model_edge();
        bit r, f;
        int p, h;
        r = drv_sig[cyc-3] && !drv_sig[cyc-4];
        f = !drv_sig[cyc-3] && drv_sig[cyc-4];
        exp_mv = 0;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (f) m_last_fall = cyc;
        if (!drv_en[cyc-1]) begin
            m_active = 0; m_measuring = 0; exp_locked = 0; exp_timeout = 0;
        end else if (!m_active) begin
            m_active = 1;
        end else if (r) begin
            if (m_measuring) begin
                p = cyc - m_last_rise;
                h = m_last_fall - m_last_rise;
                exp_locked  = m_have_prev && (p == exp_period) && (h == exp_high);
                exp_period  = p;
                exp_high    = h;
                exp_mv      = 1;
                exp_timeout = 0;
                m_have_prev = 1;
            end else begin
                m_measuring = 1;
                m_have_prev = 0;
            end
            m_last_rise = cyc;
        end else if (m_measuring && (cyc - m_last_rise == TMO)) begin
            exp_timeout = 1; exp_locked = 0; m_measuring = 0;
        end
    endtask

    // One clk_in cycle: update model at the edge, drive inputs, return at negedge.
    task automatic tick(input logic s, input logic e);
        @(posedge clk_in);
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exceeded");
        end
        model_edge();
        #1;
        sig_in = s; en = e;
        drv_sig[cyc] = s; drv_en[cyc] = e;
        @(negedge clk_in);
    endtask

    task automatic div_next(input int n, input int h, output logic s);
        s = (div_pos < h);
        div_pos = (div_pos + 1) % n;
    endtask

    task automatic test_reset();
        model_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        total++;
        if (period !== 0 || high_time !== 0 || meas_valid !== 0 || locked !== 0 || timeout !== 0) begin
            bad++;
            $display("FAIL reset_state got p=%0d h=%0d mv/lk/to=%b%b%b want all 0",
                     period, high_time, meas_valid, locked, timeout);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0);
            total++;
            if (period !== 0 || meas_valid !== 0 || locked !== 0 || timeout !== 0) begin
                bad++;
                $display("FAIL idle_after_reset cyc=%0d got p=%0d mv/lk/to=%b%b%b want 0",
                         cyc, period, meas_valid, locked, timeout);
            end
        end
    endtask

    task automatic test_div4();
        logic s;
        int c0, last_mv = 0, npulse = 0;
        div_pos = 0;
        for (int i = 0; i < 40; i++) begin
            div_next(4, 2, s);
            tick(s, 1'b1);
            if (i == 0) c0 = cyc;
            total++;
            if ({meas_valid, locked, timeout} !== {exp_mv, exp_locked, exp_timeout} ||
                period !== exp_period || high_time !== exp_high) begin
                bad++;
                $display("FAIL div4_model cyc=%0d got %b%b%b p=%0d h=%0d want %b%b%b p=%0d h=%0d",
                         cyc, meas_valid, locked, timeout, period, high_time,
                         exp_mv, exp_locked, exp_timeout, exp_period, exp_high);
            end
            if (meas_valid) begin
                npulse++;
                total++;
                if (period !== 4 || high_time !== 2 || locked !== (npulse >= 2) ||
                    (npulse == 1 && cyc != c0 + 7) || (npulse > 1 && cyc - last_mv != 4)) begin
                    bad++;
                    $display("FAIL div4_pulse n=%0d cyc=%0d got p=%0d h=%0d lk=%b gap=%0d want 4/2 lk=%b gap=4 first@%0d",
                             npulse, cyc, period, high_time, locked, cyc - last_mv, npulse >= 2, c0 + 7);
                end
                last_mv = cyc;
            end
        end
        total++;
        if (npulse != 9) begin
            bad++;
            $display("FAIL div4_count got=%0d want=9", npulse);
        end
    endtask

    task automatic test_reprogram();
        logic s;
        int n8 = 0;
        bit lk6 = 0;
        for (int i = 0; i < 84; i++) begin
            if (i < 36) div_next(6, 3, s);
            else        div_next(8, 4, s);
            tick(s, 1'b1);
            total++;
            if ({meas_valid, locked, timeout} !== {exp_mv, exp_locked, exp_timeout} ||
                period !== exp_period || high_time !== exp_high) begin
                bad++;
                $display("FAIL reprog_model cyc=%0d got %b%b%b p=%0d h=%0d want %b%b%b p=%0d h=%0d",
                         cyc, meas_valid, locked, timeout, period, high_time,
                         exp_mv, exp_locked, exp_timeout, exp_period, exp_high);
            end
            if (meas_valid && period == 6) lk6 = locked;
            if (meas_valid && period == 8) begin
                n8++;
                total++;
                if (high_time !== 4 || locked !== (n8 >= 2)) begin
                    bad++;
                    $display("FAIL reprog_8 n=%0d got h=%0d lk=%b want h=4 lk=%b",
                             n8, high_time, locked, n8 >= 2);
                end
            end
        end
        total++;
        if (!lk6 || n8 < 2) begin
            bad++;
            $display("FAIL reprog_seq got lk6=%b n8=%0d want lk6=1 n8>=2", lk6, n8);
        end
    endtask

    task automatic test_div2();
        logic s;
        int np = 0, last_mv = 0;
        for (int i = 0; i < 24; i++) begin
            div_next(2, 1, s);
            tick(s, 1'b1);
            total++;
            if ({meas_valid, locked, timeout} !== {exp_mv, exp_locked, exp_timeout} ||
                period !== exp_period || high_time !== exp_high) begin
                bad++;
                $display("FAIL div2_model cyc=%0d got %b%b%b p=%0d h=%0d want %b%b%b p=%0d h=%0d",
                         cyc, meas_valid, locked, timeout, period, high_time,
                         exp_mv, exp_locked, exp_timeout, exp_period, exp_high);
            end
            if (meas_valid) begin
                np++;
                if (np >= 3) begin
                    total++;
                    if (period !== 2 || high_time !== 1 || locked !== 1 || cyc - last_mv != 2) begin
                        bad++;
                        $display("FAIL div2_pulse cyc=%0d got p=%0d h=%0d lk=%b gap=%0d want 2/1 lk=1 gap=2",
                                 cyc, period, high_time, locked, cyc - last_mv);
                    end
                end
                last_mv = cyc;
            end
        end
    endtask

    task automatic test_timeout();
        logic s;
        int lm = 0, c0 = 0;
        bit seen = 0;
        div_pos = 0;
        for (int i = 0; i < 24; i++) begin
            div_next(4, 2, s);
            tick(s, 1'b1);
            if (meas_valid) lm = cyc;
        end
        for (int i = 0; i < 130; i++) begin
            tick(1'b0, 1'b1);
            total++;
            if ({meas_valid, locked, timeout} !== {exp_mv, exp_locked, exp_timeout}) begin
                bad++;
                $display("FAIL stall_model cyc=%0d got mv/lk/to=%b%b%b want %b%b%b",
                         cyc, meas_valid, locked, timeout, exp_mv, exp_locked, exp_timeout);
            end
            if (cyc == lm + TMO - 1) begin
                total++;
                if (timeout !== 0) begin
                    bad++;
                    $display("FAIL timeout_early cyc=%0d got to=%b want 0", cyc, timeout);
                end
            end
            if (cyc == lm + TMO) begin
                total++;
                if (timeout !== 1 || locked !== 0 || meas_valid !== 0) begin
                    bad++;
                    $display("FAIL timeout_exact cyc=%0d got to/lk/mv=%b%b%b want 100", cyc, timeout, locked, meas_valid);
                end
            end
        end
        div_pos = 0;
        for (int i = 0; i < 24; i++) begin
            div_next(4, 2, s);
            tick(s, 1'b1);
            if (i == 0) c0 = cyc;
            total++;
            if ({meas_valid, locked, timeout} !== {exp_mv, exp_locked, exp_timeout} ||
                period !== exp_period || high_time !== exp_high) begin
                bad++;
                $display("FAIL restart_model cyc=%0d got %b%b%b p=%0d h=%0d want %b%b%b p=%0d h=%0d",
                         cyc, meas_valid, locked, timeout, period, high_time,
                         exp_mv, exp_locked, exp_timeout, exp_period, exp_high);
            end
            if (!seen && meas_valid) begin
                seen = 1;
                total++;
                if (timeout !== 0 || cyc != c0 + 7 || locked !== 0) begin
                    bad++;
                    $display("FAIL restart_first cyc=%0d got to=%b lk=%b want to=0 lk=0 at cyc %0d",
                             cyc, timeout, locked, c0 + 7);
                end
            end else if (!seen) begin
                total++;
                if (timeout !== 1) begin
                    bad++;
                    $display("FAIL restart_hold cyc=%0d got to=%b want 1", cyc, timeout);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic s;
        int extra;
        extra = $urandom_range(1, 3);
        div_pos = 0;
        for (int i = 0; i < 16 + extra; i++) begin
            div_next(4, 2, s);
            tick(s, 1'b1);
        end
        #2;
        reset_n = 1'b0;
        sig_in = 1'b0;
        drv_sig[cyc] = 1'b0;
        model_reset();
        #1;
        total++;
        if (period !== 0 || high_time !== 0 || meas_valid !== 0 || locked !== 0 || timeout !== 0) begin
            bad++;
            $display("FAIL async_reset got p=%0d h=%0d mv/lk/to=%b%b%b want all 0",
                     period, high_time, meas_valid, locked, timeout);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        reset_n = 1'b1;
        div_pos = 0;
        for (int i = 0; i < 32; i++) begin
            div_next(4, 2, s);
            tick(s, 1'b1);
            total++;
            if ({meas_valid, locked, timeout} !== {exp_mv, exp_locked, exp_timeout} ||
                period !== exp_period || high_time !== exp_high) begin
                bad++;
                $display("FAIL post_reset_model cyc=%0d got %b%b%b p=%0d h=%0d want %b%b%b p=%0d h=%0d",
                         cyc, meas_valid, locked, timeout, period, high_time,
                         exp_mv, exp_locked, exp_timeout, exp_period, exp_high);
            end
        end
        total++;
        if (locked !== 1 || period !== 4) begin
            bad++;
            $display("FAIL post_reset_lock got lk=%b p=%0d want lk=1 p=4", locked, period);
        end
    endtask

    task automatic test_en_drop();
        logic s;
        logic e;
        bit seen = 0;
        div_pos = 0;
        for (int i = 0; i < 84; i++) begin
            div_next(6, 3, s);
            e = (i < 36 || i >= 46);
            tick(s, e);
            total++;
            if ({meas_valid, locked, timeout} !== {exp_mv, exp_locked, exp_timeout} ||
                period !== exp_period || high_time !== exp_high) begin
                bad++;
                $display("FAIL en_model cyc=%0d got %b%b%b p=%0d h=%0d want %b%b%b p=%0d h=%0d",
                         cyc, meas_valid, locked, timeout, period, high_time,
                         exp_mv, exp_locked, exp_timeout, exp_period, exp_high);
            end
            if (i == 35) begin
                total++;
                if (locked !== 1) begin
                    bad++;
                    $display("FAIL en_prelock got lk=%b want 1", locked);
                end
            end
            if (i >= 37 && i < 46) begin
                total++;
                if (locked !== 0 || timeout !== 0 || meas_valid !== 0 || period !== 6) begin
                    bad++;
                    $display("FAIL en_low cyc=%0d got lk/to/mv=%b%b%b p=%0d want 000 p=6",
                             cyc, locked, timeout, meas_valid, period);
                end
            end
            if (i >= 46 && meas_valid && !seen) begin
                seen = 1;
                total++;
                if (locked !== 0 || period !== 6 || cyc - drv_first_en(cyc) < 8) begin
                    bad++;
                    $display("FAIL en_rearm cyc=%0d got lk=%b p=%0d want lk=0 p=6 after two rises",
                             cyc, locked, period);
                end
            end
        end
        for (int i = 0; i < 110; i++) tick(1'b0, 1'b1);
        total++;
        if (timeout !== 1) begin
            bad++;
            $display("FAIL en_pre_timeout got to=%b want 1", timeout);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        total++;
        if (timeout !== 0 || locked !== 0) begin
            bad++;
            $display("FAIL en_clears_timeout got to=%b lk=%b want 0 0", timeout, locked);
        end
    endtask

    // Cycle at which en was last driven high after being low, searching back from c.
    function automatic int drv_first_en(input int c);
        int k;
        k = c;
        while (k > 5 && drv_en[k-1]) k--;
        return k;
    endfunction

    task automatic test_odd5();
        logic s;
        int h = 2, np = 0;
        div_pos = 0;
        for (int i = 0; i < 150; i++) begin
            if (div_pos == 0) h = $urandom_range(2, 3);
            div_next(5, h, s);
            tick(s, 1'b1);
            total++;
            if ({meas_valid, locked, timeout} !== {exp_mv, exp_locked, exp_timeout} ||
                period !== exp_period || high_time !== exp_high) begin
                bad++;
                $display("FAIL odd5_model cyc=%0d got %b%b%b p=%0d h=%0d want %b%b%b p=%0d h=%0d",
                         cyc, meas_valid, locked, timeout, period, high_time,
                         exp_mv, exp_locked, exp_timeout, exp_period, exp_high);
            end
            if (meas_valid) begin
                np++;
                total++;
                if (period !== 5 || !(high_time inside {2, 3})) begin
                    bad++;
                    $display("FAIL odd5_range cyc=%0d got p=%0d h=%0d want p=5 h in 2..3", cyc, period, high_time);
                end
            end
        end
        total++;
        if (np < 25) begin
            bad++;
            $display("FAIL odd5_count got=%0d want>=25", np);
        end
    endtask

    task automatic test_random();
        logic s;
        int n, h, len, gap;
        for (int seg = 0; seg < 8; seg++) begin
            n   = $urandom_range(2, 12);
            h   = $urandom_range(1, n - 1);
            len = n * $urandom_range(3, 8);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            div_pos = 0;
            for (int i = 0; i < len; i++) begin
                div_next(n, h, s);
                tick(s, i >= gap);
                total++;
                if ({meas_valid, locked, timeout} !== {exp_mv, exp_locked, exp_timeout} ||
                    period !== exp_period || high_time !== exp_high) begin
                    bad++;
                    $display("FAIL random_model seg=%0d n=%0d cyc=%0d got %b%b%b p=%0d h=%0d want %b%b%b p=%0d h=%0d",
                             seg, n, cyc, meas_valid, locked, timeout, period, high_time,
                             exp_mv, exp_locked, exp_timeout, exp_period, exp_high);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            drv_sig[i] = 1'b0;
            drv_en[i]  = 1'b0;
        end
        model_reset();
        m_last_rise = 0;
        m_last_fall = 0;
        test_reset();
        test_div4();
        test_reprogram();
        test_div2();
        test_timeout();
        test_reset_mid();
        test_en_drop();
        test_odd5();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_ratio_meter.md
# clk_ratio_meter

Measures the period and high time of a slow divided clock, `sig_in`, in cycles of the system clock `clk_in`. This is the receive-side counterpart of the clock divider. It recovers the divide ratio N and the duty from the waveform, and reports when the ratio is stable. In the Modbus RTU slave it checks the baud and tick clocks on silicon and in simulation, and it can monitor an externally supplied reference clock.

## Interface
- `CNT_W`, 32: width of all counters and measurement outputs.
- `TIMEOUT`, 32'd1000000: clk_in cycles allowed without a rising edge before signal loss is declared. Range 2..2^CNT_W-1.

- `clk_in`  in  1  system clock; all logic runs on its rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  measurement enable; level-sensitive.
- `sig_in`  in  1  clock under test; may be asynchronous to clk_in.
- `period`  out  CNT_W  last measured rising-to-rising interval, in clk_in cycles.
- `high_time`  out  CNT_W  high phase belonging to `period`, in clk_in cycles.
- `meas_valid`  out  1  one-cycle pulse when `period` and `high_time` update.
- `locked`  out  1  last two measurements identical.
- `timeout`  out  1  sticky signal-loss flag.

## Operation
- Input path: 2-flop synchronizer, then a history flop. Rise = s2 & ~s3; fall = ~s2 & s3.
- Counter `cnt`:
  - cleared to 0 on a detected rise;
  - otherwise increments by 1 and saturates at TIMEOUT-1;
  - never wraps.
- High-time capture: on a detected fall, internal `hi_cap <= cnt+1`.
- FSM states: IDLE, WAIT_RISE, MEASURE.
  - IDLE: entered when `en`=0 (evaluated every cycle, from any state). `cnt`=0, `locked`=0, `timeout`=0. `period` and `high_time` hold their values. Exits to WAIT_RISE when `en`=1.
  - WAIT_RISE: on the first detected rise, clear `cnt` and go to MEASURE. No output update.
  - MEASURE: on a detected rise:
    - `period <= cnt+1` and `high_time <= hi_cap`;
    - pulse `meas_valid`;
    - clear `timeout`;
    - `locked <= (cnt+1 == period) && (hi_cap == high_time)`, comparing against the previous outputs;
    - clear `cnt` and stay in MEASURE.
  - MEASURE, on `cnt` reaching TIMEOUT-1 with no rise: set `timeout`, clear `locked`, go to WAIT_RISE. No `meas_valid`.
- A rise and a timeout in the same cycle: the rise wins (normal measurement).
- The first measurement after entering MEASURE can never assert `locked`. The earliest possible `locked` is the second `meas_valid`.
- Synchronous source timing: each phase of `sig_in` ≥1 clk_in cycle. Divide-by-2 gives period 2 and high_time 1.
- Asynchronous source timing: each phase must be ≥2 clk_in cycles. Results may jitter by ±1 cycle.
- Odd N with half-cycle edges (the divider's odd mode): `period` = N. `high_time` alternates between (N-1)/2 and (N+1)/2 depending on sampling phase.

## Timing
- Reset values: `period`=0, `high_time`=0, `meas_valid`=0, `locked`=0, `timeout`=0; FSM in IDLE; `cnt`=0; synchronizer flops 0.
- All outputs are registered.
- Latency: a `sig_in` transition after clk_in edge k is detected in cycle k+2. The corresponding output update (`meas_valid`, `period`) is visible after edge k+3.
- `meas_valid`:
  - exactly one cycle high per completed period;
  - never high in two consecutive cycles unless period = 1, which is not achievable;
  - pulses are N cycles apart for a stable divide ratio N.
- `timeout` asserts exactly TIMEOUT cycles after the last detected rise.
- `en` low: state is IDLE from the next edge. A measurement in progress is discarded.
- `reset_n` assertion mid-measurement: all outputs return to reset values immediately (asynchronous).
- `reset_n` release: operation starts from IDLE on the next rising edge of clk_in.

## Structure
- Package `clk_meas_pkg`:
  - FSM state encoding (IDLE=2'd0, WAIT_RISE=2'd1, MEASURE=2'd2);
  - default `CNT_W`;
  - default `TIMEOUT`.
- Sub-module `sync_edge_det`:
  - 2-flop synchronizer plus history flop;
  - outputs `rise`/`fall` pulses;
  - async active-low reset.
- Top level: FSM, counter, capture registers, lock compare.

## Test plan
- Clock divider N=4 drives `sig_in`, `en`=1:
  - first `meas_valid` on the second detected rise, with `period`=4 and `high_time`=2;
  - `locked`=1 from the second `meas_valid` onward;
  - pulses exactly 4 cycles apart.
- N=6, then reprogram to N=8 mid-stream:
  - 6/3 with `locked`=1;
  - first 8/4 measurement has `locked`=0;
  - next measurement 8/4 with `locked`=1.
- N=2: `period`=2 and `high_time`=1, with `meas_valid` every 2 cycles.
- TIMEOUT=100, `sig_in` held low after lock:
  - `timeout`=1 and `locked`=0 exactly 100 cycles after the last rise;
  - no `meas_valid` while stalled;
  - on restart, `timeout` clears with the second rise's `meas_valid`.
- `reset_n` pulsed low mid-period: all outputs 0 at once, and measurement restarts cleanly.
- `en` dropped for 10 cycles: `locked` and `timeout` clear, `period` holds, and re-arm requires two rises before the next `meas_valid`.
- N=5 odd mode: every measurement gives `period`=5 and `high_time`∈{2,3}.
